pb_io_regfile: RTL

Parametrised PicoBlaze (kcpsm6) I/O register bridge. It is the successor to the fixed four-in/four-out nexys4_if.
- Provides N_IN read-only input ports, N_OUT read/write output registers, and an N_IRQ-source edge-triggered interrupt controller with status and mask registers.
- Drives the kcpsm6 interrupt/interrupt_ack handshake.
- Sits between the kcpsm6 port bus and board-level I/O (debounced switches/buttons, LEDs, seven-segment digits, peripheral event lines).

---
 rtl/pb_io_regfile.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pb_io_regfile.sv
// kcpsm6 port-bus bridge: N_IN input ports, N_OUT output registers, N_IRQ edge IRQ controller.
// Latency: reads registered (1 cycle), writes visible next cycle; no backpressure.
// PB_IO_SYNC_EN adds two-flop synchronisers on in_ports and irq_src (+2 cycles).
module pb_io_regfile #(
  parameter int         N_IN      = 4,
  parameter int         N_OUT     = 4,
  parameter int         N_IRQ     = 4,
  parameter logic [7:0] OUT_BASE  = 8'h10,
  parameter logic [7:0] IRQ_BASE  = 8'h20,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           io_data_in,
  output logic [7:0]           io_data_out,
  input  logic [N_IN*8-1:0]    in_ports,
  output logic [N_OUT*8-1:0]   out_ports,
  input  logic [N_IRQ-1:0]     irq_src,
  output logic                 interrupt,
  input  logic                 interrupt_ack
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERTED   = 2'd1,
    WAIT_REARM = 2'd2
  } irq_state_e;

  localparam logic [7:0] MASK_ADDR = IRQ_BASE + 8'd1;

  localparam int  OB          = int'(OUT_BASE);
  localparam int  IB          = int'(IRQ_BASE);
  localparam bit  CFG_OVERLAP = (OB < N_IN) || ((OB <= IB + 1) && (IB <= OB + N_OUT - 1));

  logic [N_IN*8-1:0]  in_use;
  logic [N_IRQ-1:0]   irq_use;

  logic [N_OUT*8-1:0] out_q, out_d;
  logic [N_IRQ-1:0]   status_q, status_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [N_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [N_IRQ-1:0]   irq_rise;

  logic               stat_wr;
  logic               mask_wr;

  irq_state_e         state_q;
  logic               int_q;
  logic               armed_q;

  // read_strobe carries no side effects in this bridge
  logic               unused_rd;
  assign unused_rd = read_strobe;

`ifdef PB_IO_SYNC_EN
  logic [N_IN*8-1:0] in_s1_q, in_s1_d, in_s2_q, in_s2_d;
  logic [N_IRQ-1:0]  irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;

  always_comb begin
    in_s1_d  = in_ports;
    in_s2_d  = in_s1_q;
    irq_s1_d = irq_src;
    irq_s2_d = irq_s1_q;
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      in_s1_q  <= '0;
      in_s2_q  <= '0;
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      in_s1_q  <= in_s1_d;
      in_s2_q  <= in_s2_d;
      irq_s1_q <= irq_s1_d;
      irq_s2_q <= irq_s2_d;
    end
  end

  assign in_use  = in_s2_q;
  assign irq_use = irq_s2_q;
`else
  assign in_use  = in_ports;
  assign irq_use = irq_src;
`endif

  assign stat_wr = write_strobe && (port_id == IRQ_BASE);
  assign mask_wr = write_strobe && (port_id == MASK_ADDR);

  always_comb begin
    out_d      = out_q;
    mask_d     = mask_q;
    status_d   = status_q;
    irq_prev_d = irq_use;
    irq_rise   = irq_use & ~irq_prev_q;
    rdata_d    = '0;

    for (int j = 0; j < N_OUT; j++) begin
      if (write_strobe && (port_id == OUT_BASE + 8'(j))) begin
        out_d[j*8 +: 8] = io_data_in;
      end
    end

    if (mask_wr) begin
      mask_d = io_data_in[N_IRQ-1:0];
    end

    // W1C applied first so a same-cycle rising edge wins
    if (stat_wr) begin
      status_d = status_q & ~io_data_in[N_IRQ-1:0];
    end
    status_d = status_d | irq_rise;

    for (int i = 0; i < N_IN; i++) begin
      if (port_id == 8'(i)) begin
        rdata_d = in_use[i*8 +: 8];
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (port_id == OUT_BASE + 8'(j)) begin
        rdata_d = out_q[j*8 +: 8];
      end
    end
    if (port_id == IRQ_BASE) begin
      rdata_d[N_IRQ-1:0] = status_q;
    end
    if (port_id == MASK_ADDR) begin
      rdata_d[N_IRQ-1:0] = mask_q;
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      out_q      <= {N_OUT{OUT_RESET}};
      status_q   <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      rdata_q    <= '0;
    end else begin
      out_q      <= out_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_prev_d;
      rdata_q    <= rdata_d;
    end
  end

  // Interrupt handshake; once acked, software must touch status or mask to re-arm
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q && (|(status_q & mask_q))) begin
            int_q   <= 1'b1;
            state_q <= ASSERTED;
          end
        end
        ASSERTED: begin
          if (interrupt_ack) begin
            int_q   <= 1'b0;
            armed_q <= 1'b0;
            state_q <= WAIT_REARM;
          end
        end
        WAIT_REARM: begin
          if (stat_wr || mask_wr) begin
            armed_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          int_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_data_out = rdata_q;
  assign out_ports   = out_q;
  assign interrupt   = int_q;

`ifndef SYNTHESIS
  always @(posedge sysclk) begin
    if (!sysreset) begin
      assert (!CFG_OVERLAP)
        else $error("pb_io_regfile: output register range overlaps input or IRQ range");
    end
  end
`endif

endmodule
